generic_sram_axi4_master_bridge: RTL and testbench

- Reverse-direction companion to the AXI4-slave-to-SRAM bridges.
- Presents a byte-enable SRAM-style target to a local client and converts each SRAM access into a single-beat AXI4 master transaction.
- Lets SRAM-style engines (DMA, table walkers) reach AXI4 memory. Adds busy/done because AXI latency is unbounded.

---
 rtl/generic_sram_axi4_master_bridge_if.sv | 88 ++++++++
 rtl/generic_sram_axi4_master_bridge.sv | 153 +++++++++++++++
 tb/tb_generic_sram_axi4_master_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/generic_sram_axi4_master_bridge_if.sv
// Port bundles for the SRAM-to-AXI4 master bridge: a byte-enable SRAM target
// port (the bridge plays the SRAM) and a single AXI4 bus.

interface generic_sram_byte_en_if #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_BITS-1:0]    addr;
    logic                    read_en;
    logic                    write_en;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH-1:0]   read_data;

    modport sram   (input addr, read_en, write_en, byte_en, write_data, output read_data);
    modport client (output addr, read_en, write_en, byte_en, write_data, input read_data);
endinterface

interface axi4_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/generic_sram_axi4_master_bridge.sv
// Byte-enable SRAM target that turns every access into one single-beat AXI4
// master transaction; busy/done expose the unbounded bus latency to the client.

module generic_sram_axi4_master_bridge #(
    parameter int unsigned                  MEM_ADDR_BITS     = 10,
    parameter int unsigned                  AXI_ADDRESS_WIDTH = 32,
    parameter int unsigned                  AXI_DATA_WIDTH    = 32,
    parameter int unsigned                  AXI_ID_WIDTH      = 4,
    parameter logic [AXI_ID_WIDTH-1:0]      AXI_ID            = '0,
    parameter logic [AXI_ADDRESS_WIDTH-1:0] BASE_ADDR         = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    generic_sram_byte_en_if.sram sram_if,
    output logic                 busy,
    output logic                 done,
    output logic                 resp_err,
    input  logic                 err_clr,
    axi4_if.master               axi_if
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(STRB_WIDTH);

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R} state_t;

    state_t                       state_q, state_d;
    logic                         aw_pend_q, aw_pend_d;
    logic                         w_pend_q, w_pend_d;
    logic                         accept_wr, accept_rd, rd_capture, err_set, done_d;
    logic [MEM_ADDR_BITS-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0]    wdata_q, rdata_q;
    logic [STRB_WIDTH-1:0]        strb_q;
    logic [AXI_ADDRESS_WIDTH-1:0] ax_addr;
    logic                         unused_resp_fields;

    // IDs and RLAST carry no information with a single outstanding single-beat transaction
    assign unused_resp_fields = ^{axi_if.bid, axi_if.rid, axi_if.rlast};

    assign ax_addr = BASE_ADDR + (AXI_ADDRESS_WIDTH'(addr_q) << BYTE_SHIFT);

    always_comb begin
        state_d    = state_q;
        aw_pend_d  = aw_pend_q;
        w_pend_d   = w_pend_q;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        rd_capture = 1'b0;
        err_set    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sram_if.write_en) begin
                    accept_wr = 1'b1;
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    state_d   = WR;
                end else if (sram_if.read_en) begin
                    accept_rd = 1'b1;
                    state_d   = RD_A;
                end
            end
            WR: begin
                // AW and W retire independently, in either order or together
                if (aw_pend_q && axi_if.awready) aw_pend_d = 1'b0;
                if (w_pend_q && axi_if.wready)   w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d)     state_d   = WR_B;
            end
            WR_B: begin
                if (axi_if.bvalid) begin
                    err_set = |axi_if.bresp;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_A: begin
                if (axi_if.arready) state_d = RD_R;
            end
            RD_R: begin
                if (axi_if.rvalid) begin
                    rd_capture = 1'b1;
                    err_set    = |axi_if.rresp;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            done      <= 1'b0;
            resp_err  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            done      <= done_d;
            if (accept_wr || accept_rd) addr_q <= sram_if.addr;
            if (accept_wr) begin
                wdata_q <= sram_if.write_data;
                strb_q  <= sram_if.byte_en;
            end
            if (rd_capture) rdata_q <= axi_if.rdata;
            // a newly reported error outranks a simultaneous clear
            if (err_set)      resp_err <= 1'b1;
            else if (err_clr) resp_err <= 1'b0;
        end
    end

    assign busy              = (state_q != IDLE);
    assign sram_if.read_data = rdata_q;

    assign axi_if.awid     = AXI_ID;
    assign axi_if.awaddr   = ax_addr;
    assign axi_if.awlen    = '0;
    assign axi_if.awsize   = 3'(BYTE_SHIFT);
    assign axi_if.awburst  = 2'b01;
    assign axi_if.awlock   = 1'b0;
    assign axi_if.awcache  = '0;
    assign axi_if.awprot   = '0;
    assign axi_if.awqos    = '0;
    assign axi_if.awregion = '0;
    assign axi_if.awvalid  = (state_q == WR) && aw_pend_q;

    assign axi_if.wdata  = wdata_q;
    assign axi_if.wstrb  = strb_q;
    assign axi_if.wlast  = 1'b1;
    assign axi_if.wvalid = (state_q == WR) && w_pend_q;

    assign axi_if.bready = (state_q == WR_B);

    assign axi_if.arid     = AXI_ID;
    assign axi_if.araddr   = ax_addr;
    assign axi_if.arlen    = '0;
    assign axi_if.arsize   = 3'(BYTE_SHIFT);
    assign axi_if.arburst  = 2'b01;
    assign axi_if.arlock   = 1'b0;
    assign axi_if.arcache  = '0;
    assign axi_if.arprot   = '0;
    assign axi_if.arqos    = '0;
    assign axi_if.arregion = '0;
    assign axi_if.arvalid  = (state_q == RD_A);

    assign axi_if.rready = (state_q == RD_R);
endmodule

// File: tb/tb_generic_sram_axi4_master_bridge.sv
// Directed bench for the SRAM-to-AXI4 master bridge; the bench acts as the AXI slave.

module tb_generic_sram_axi4_master_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    generic_sram_byte_en_if #(.ADDR_BITS(10), .DATA_WIDTH(32)) sif0 ();
    generic_sram_byte_en_if #(.ADDR_BITS(10), .DATA_WIDTH(32)) sif1 ();
    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) aif0 ();
    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) aif1 ();

    logic busy0, done0, err0, clr0;
    logic busy1, done1, err1, clr1;

    generic_sram_axi4_master_bridge #(
        .MEM_ADDR_BITS(10), .AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH(4), .AXI_ID(4'h5), .BASE_ADDR(32'h0000_0000)
    ) dut0 (
        .clk(clk), .rst(rst), .sram_if(sif0), .busy(busy0), .done(done0),
        .resp_err(err0), .err_clr(clr0), .axi_if(aif0)
    );

    generic_sram_axi4_master_bridge #(
        .MEM_ADDR_BITS(10), .AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH(4), .AXI_ID(4'hA), .BASE_ADDR(32'h1000_0000)
    ) dut1 (
        .clk(clk), .rst(rst), .sram_if(sif1), .busy(busy1), .done(done1),
        .resp_err(err1), .err_clr(clr1), .axi_if(aif1)
    );

    // handshake counters and captured payloads on the main DUT's bus
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    always @(posedge clk) begin
        if (aif0.awvalid && aif0.awready) begin aw_hs <= aw_hs + 1; last_awaddr <= aif0.awaddr; end
        if (aif0.wvalid && aif0.wready) begin w_hs <= w_hs + 1; last_wdata <= aif0.wdata; last_wstrb <= aif0.wstrb; end
        if (aif0.bvalid && aif0.bready) b_hs <= b_hs + 1;
        if (aif0.arvalid && aif0.arready) begin ar_hs <= ar_hs + 1; last_araddr <= aif0.araddr; end
        if (aif0.rvalid && aif0.rready) r_hs <= r_hs + 1;
    end

    // zero-wait write on dut0; returns at the negedge where done is visible
    task run_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be, input logic [1:0] resp);
        sif0.addr = a; sif0.write_data = d; sif0.byte_en = be; sif0.write_en = 1'b1;
        aif0.awready = 1'b1; aif0.wready = 1'b1;
        @(negedge clk);
        sif0.write_en = 1'b0;
        @(negedge clk);
        aif0.awready = 1'b0; aif0.wready = 1'b0; aif0.bvalid = 1'b1; aif0.bresp = resp;
        @(negedge clk);
        aif0.bvalid = 1'b0; aif0.bresp = 2'b00;
    endtask

    task run_read(input logic [9:0] a, input logic [31:0] d, input logic [1:0] resp, input logic clr);
        sif0.addr = a; sif0.read_en = 1'b1; aif0.arready = 1'b1;
        @(negedge clk);
        sif0.read_en = 1'b0;
        @(negedge clk);
        aif0.arready = 1'b0; aif0.rvalid = 1'b1; aif0.rdata = d; aif0.rresp = resp; clr0 = clr;
        @(negedge clk);
        aif0.rvalid = 1'b0; aif0.rresp = 2'b00; clr0 = 1'b0;
    endtask

    task test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_run++;
        if ({busy0, done0, err0, aif0.awvalid, aif0.wvalid, aif0.arvalid, aif0.bready, aif0.rready} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl0: got %b want 00000000", {busy0, done0, err0, aif0.awvalid, aif0.wvalid, aif0.arvalid, aif0.bready, aif0.rready});
        end
        n_run++;
        if ({busy1, done1, err1, aif1.arvalid, aif1.rready, sif0.read_data, sif1.read_data} !== 69'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rd0=%h rd1=%h ctrl1=%b want all zero", sif0.read_data, sif1.read_data, {busy1, done1, err1, aif1.arvalid, aif1.rready});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task test_write_basic;
        int lat, ndone, aw0, w0, b0;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; lat = 0; ndone = 0;
        sif0.addr = 10'h005; sif0.write_data = 32'hDEADBEEF; sif0.byte_en = 4'hF; sif0.write_en = 1'b1;
        aif0.awready = 1'b1; aif0.wready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            sif0.write_en = 1'b0;
            if (c == 1) begin
                n_run++;
                if ({aif0.awvalid, aif0.wvalid, aif0.awaddr, aif0.wdata, aif0.wstrb, aif0.wlast, busy0} !== {1'b1, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL wr_payload: got v=%b%b addr=%h data=%h strb=%h last=%b busy=%b want 11 00000014 deadbeef f 1 1",
                             aif0.awvalid, aif0.wvalid, aif0.awaddr, aif0.wdata, aif0.wstrb, aif0.wlast, busy0);
                end
                n_run++;
                if ({aif0.awlen, aif0.awsize, aif0.awburst, aif0.awid, aif0.awlock, aif0.awcache, aif0.awprot, aif0.awqos, aif0.awregion}
                    !== {8'd0, 3'd2, 2'b01, 4'h5, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0}) begin
                    n_fail++;
                    $display("FAIL wr_fixed_fields: got len=%0d size=%0d burst=%b id=%h lock=%b cache=%h prot=%h qos=%h region=%h want 0 2 01 5 0 0 0 0 0",
                             aif0.awlen, aif0.awsize, aif0.awburst, aif0.awid, aif0.awlock, aif0.awcache, aif0.awprot, aif0.awqos, aif0.awregion);
                end
            end
            if (done0) begin ndone++; if (lat == 0) lat = c; end
            aif0.bvalid = (c == 2);
        end
        aif0.awready = 1'b0; aif0.wready = 1'b0; aif0.bvalid = 1'b0;
        n_run++;
        if (lat !== 3 || ndone !== 1) begin
            n_fail++;
            $display("FAIL wr_latency: got done in cycle %0d (%0d pulses) want cycle 3 (1 pulse)", lat, ndone);
        end
        n_run++;
        if ({aw_hs - aw0, w_hs - w0, b_hs - b0} !== {32'd1, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL wr_hs_count: got aw=%0d w=%0d b=%0d want 1 1 1", aw_hs - aw0, w_hs - w0, b_hs - b0);
        end
    endtask

    task test_read_base;
        int bad;
        bad = 0;
        sif1.addr = 10'h3FF; sif1.read_en = 1'b1;
        @(negedge clk);
        sif1.read_en = 1'b0;
        n_run++;
        if ({aif1.arvalid, aif1.araddr, aif1.arlen, aif1.arsize, aif1.arburst, aif1.arid, busy1} !== {1'b1, 32'h1000_0FFC, 8'd0, 3'd2, 2'b01, 4'hA, 1'b1}) begin
            n_fail++;
            $display("FAIL rd_addr: got v=%b addr=%h len=%0d size=%0d burst=%b id=%h busy=%b want 1 10000ffc 0 2 01 a 1",
                     aif1.arvalid, aif1.araddr, aif1.arlen, aif1.arsize, aif1.arburst, aif1.arid, busy1);
        end
        aif1.arready = 1'b1;
        @(negedge clk);
        aif1.arready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            if (!(busy1 && aif1.rready && !aif1.arvalid && !done1)) bad++;
            @(negedge clk);
        end
        n_run++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rd_wait_busy: got %0d bad wait cycles want 0", bad);
        end
        aif1.rvalid = 1'b1; aif1.rdata = 32'h12345678; aif1.rresp = 2'b00;
        @(negedge clk);
        aif1.rvalid = 1'b0;
        n_run++;
        if ({done1, busy1, aif1.rready, sif1.read_data} !== {1'b1, 1'b0, 1'b0, 32'h12345678}) begin
            n_fail++;
            $display("FAIL rd_done_data: got done=%b busy=%b rready=%b data=%h want 1 0 0 12345678", done1, busy1, aif1.rready, sif1.read_data);
        end
    endtask

    task test_write_order;
        int aw_lat[3] = '{5, 1, 3};
        int w_lat[3]  = '{1, 5, 3};
        int aw0, w0, b0, mx;
        logic [31:0] ea, ed;
        for (int k = 0; k < 3; k++) begin
            aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
            mx = (aw_lat[k] > w_lat[k]) ? aw_lat[k] : w_lat[k];
            ea = 32'h100 + 32'(k) * 4; ed = 32'h1111_0000 + 32'(k);
            sif0.addr = 10'h040 + 10'(k); sif0.write_data = ed; sif0.byte_en = 4'hF; sif0.write_en = 1'b1;
            @(negedge clk);
            sif0.write_en = 1'b0;
            for (int c = 1; c <= mx; c++) begin
                aif0.awready = (c == aw_lat[k]); aif0.wready = (c == w_lat[k]);
                @(negedge clk);
                n_run++;
                if ({aif0.awvalid, aif0.wvalid, aif0.bready, aif0.awaddr, aif0.wdata} !== {c < aw_lat[k], c < w_lat[k], c >= mx, ea, ed}) begin
                    n_fail++;
                    $display("FAIL wr_order case%0d cyc%0d: got aw=%b w=%b b=%b addr=%h data=%h want %b %b %b %h %h",
                             k, c, aif0.awvalid, aif0.wvalid, aif0.bready, aif0.awaddr, aif0.wdata, c < aw_lat[k], c < w_lat[k], c >= mx, ea, ed);
                end
            end
            aif0.awready = 1'b0; aif0.wready = 1'b0;
            aif0.bvalid = 1'b1;
            repeat (2) @(negedge clk);
            aif0.bvalid = 1'b0;
            n_run++;
            if ({aw_hs - aw0, w_hs - w0, b_hs - b0} !== {32'd1, 32'd1, 32'd1}) begin
                n_fail++;
                $display("FAIL wr_order_hs case%0d: got aw=%0d w=%0d b=%0d want 1 1 1", k, aw_hs - aw0, w_hs - w0, b_hs - b0);
            end
        end
    endtask

    task test_write_wins;
        int aw0, ar0;
        aw0 = aw_hs; ar0 = ar_hs;
        sif0.addr = 10'h002; sif0.write_data = 32'h0BAD_F00D; sif0.byte_en = 4'h3;
        sif0.write_en = 1'b1; sif0.read_en = 1'b1;
        @(negedge clk);
        sif0.write_en = 1'b0; sif0.addr = 10'h011;
        for (int c = 0; c < 2; c++) begin
            n_run++;
            if ({aif0.awvalid, aif0.wvalid, aif0.arvalid, busy0, aif0.awaddr, aif0.wstrb, aif0.wdata} !== {4'b1101, 32'h8, 4'h3, 32'h0BAD_F00D}) begin
                n_fail++;
                $display("FAIL wr_wins cyc%0d: got aw=%b w=%b ar=%b busy=%b addr=%h strb=%h data=%h want 1 1 0 1 00000008 3 0badf00d",
                         c, aif0.awvalid, aif0.wvalid, aif0.arvalid, busy0, aif0.awaddr, aif0.wstrb, aif0.wdata);
            end
            @(negedge clk);
        end
        sif0.read_en = 1'b0; aif0.awready = 1'b1; aif0.wready = 1'b1;
        @(negedge clk);
        aif0.awready = 1'b0; aif0.wready = 1'b0; aif0.bvalid = 1'b1;
        @(negedge clk);
        aif0.bvalid = 1'b0;
        repeat (3) @(negedge clk);
        n_run++;
        if ({aw_hs - aw0, ar_hs - ar0, 31'(0), aif0.arvalid, busy0} !== {32'd1, 32'd0, 33'd0}) begin
            n_fail++;
            $display("FAIL busy_ignore: got aw=%0d ar=%0d arvalid=%b busy=%b want 1 0 0 0", aw_hs - aw0, ar_hs - ar0, aif0.arvalid, busy0);
        end
    endtask

    task test_back_to_back;
        run_write(10'h007, 32'h55AA_33CC, 4'h0, 2'b00);
        n_run++;
        if ({done0, busy0} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_wr_done: got done=%b busy=%b want 1 0", done0, busy0);
        end
        run_read(10'h009, 32'hCAFE_F00D, 2'b00, 1'b0);
        n_run++;
        if ({done0, busy0, sif0.read_data} !== {2'b10, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL b2b_rd_done: got done=%b busy=%b data=%h want 1 0 cafef00d", done0, busy0, sif0.read_data);
        end
        n_run++;
        if ({last_awaddr, last_wdata, last_wstrb, last_araddr} !== {32'h1C, 32'h55AA_33CC, 4'h0, 32'h24}) begin
            n_fail++;
            $display("FAIL b2b_payload: got awaddr=%h wdata=%h wstrb=%h araddr=%h want 0000001c 55aa33cc 0 00000024",
                     last_awaddr, last_wdata, last_wstrb, last_araddr);
        end
    endtask

    task test_resp_err;
        run_write(10'h020, 32'h1, 4'hF, 2'b10);
        n_run++;
        if ({err0, sif0.read_data} !== {1'b1, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL err_slverr: got err=%b data=%h want 1 cafef00d", err0, sif0.read_data);
        end
        run_read(10'h021, 32'h0000_1234, 2'b00, 1'b0);
        n_run++;
        if ({err0, sif0.read_data} !== {1'b1, 32'h0000_1234}) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b data=%h want 1 00001234", err0, sif0.read_data);
        end
        run_read(10'h022, 32'h0000_5678, 2'b11, 1'b1);
        n_run++;
        if (err0 !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set_wins: got err=%b want 1", err0);
        end
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        n_run++;
        if (err0 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b want 0", err0);
        end
        run_write(10'h023, 32'h2, 4'hF, 2'b10);
        @(negedge clk);
        n_run++;
        if (err0 !== 1'b1) begin
            n_fail++;
            $display("FAIL err_reset_again: got err=%b want 1", err0);
        end
    endtask

    task test_reset_mid_read;
        sif0.addr = 10'h030; sif0.read_en = 1'b1; aif0.arready = 1'b1;
        @(negedge clk);
        sif0.read_en = 1'b0;
        @(negedge clk);
        aif0.arready = 1'b0;
        n_run++;
        if ({aif0.rready, busy0} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_rd_state: got rready=%b busy=%b want 1 1", aif0.rready, busy0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_run++;
        if ({aif0.rready, aif0.arvalid, busy0, done0, err0, sif0.read_data} !== 37'h0) begin
            n_fail++;
            $display("FAIL mid_rd_reset: got rready=%b arvalid=%b busy=%b done=%b err=%b data=%h want all zero",
                     aif0.rready, aif0.arvalid, busy0, done0, err0, sif0.read_data);
        end
    endtask

    initial begin
        sif0.addr = '0; sif0.read_en = 1'b0; sif0.write_en = 1'b0; sif0.byte_en = '0; sif0.write_data = '0;
        sif1.addr = '0; sif1.read_en = 1'b0; sif1.write_en = 1'b0; sif1.byte_en = '0; sif1.write_data = '0;
        aif0.awready = 1'b0; aif0.wready = 1'b0; aif0.bid = '0; aif0.bresp = '0; aif0.bvalid = 1'b0;
        aif0.arready = 1'b0; aif0.rid = '0; aif0.rdata = '0; aif0.rresp = '0; aif0.rlast = 1'b1; aif0.rvalid = 1'b0;
        aif1.awready = 1'b0; aif1.wready = 1'b0; aif1.bid = '0; aif1.bresp = '0; aif1.bvalid = 1'b0;
        aif1.arready = 1'b0; aif1.rid = '0; aif1.rdata = '0; aif1.rresp = '0; aif1.rlast = 1'b1; aif1.rvalid = 1'b0;
        clr0 = 1'b0; clr1 = 1'b0;

        test_reset();
        test_write_basic();
        test_read_base();
        test_write_order();
        test_write_wins();
        test_back_to_back();
        test_resp_err();
        test_reset_mid_read();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
